// File: rtl/seq_bw_mult_pkg.sv
// rtl/seq_bw_mult_pkg.sv - shared types and Baugh-Wooley row/preload helpers for seq_bw_mult
package seq_bw_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Helpers work on the widest legal operand and product; callers slice down.
  localparam int MAX_WIDTH = 32;
  localparam int MAX_PROD  = 2 * MAX_WIDTH;

  // One partial-product row, already shifted into product position.
  // In signed mode a bit is inverted when exactly one of (row, column)
  // is the sign position; the sign*sign bit keeps its true polarity.
  function automatic logic [MAX_PROD-1:0] bw_row(
    input logic [MAX_WIDTH-1:0] a,
    input logic                 b_bit,
    input int                   row,
    input logic                 signed_mode,
    input int                   width
  );
    logic [MAX_PROD-1:0] r;
    logic                pb;
    r = '0;
    for (int j = 0; j < MAX_WIDTH; j++) begin
      if (j < width) begin
        pb = a[j] & b_bit;
        if (signed_mode && ((row == width - 1) != (j == width - 1))) begin
          pb = ~pb;
        end
        r[j] = pb;
      end
    end
    r = r << row;
    if (width < MAX_WIDTH) begin
      r = r & ((MAX_PROD'(1) << (2 * width)) - MAX_PROD'(1));
    end
    return r;
  endfunction

  // Constant that turns the inverted rows back into a two's-complement sum.
  function automatic logic [MAX_PROD-1:0] bw_preload(
    input logic signed_mode,
    input int   width
  );
    logic [MAX_PROD-1:0] r;
    r = '0;
    if (signed_mode) begin
      r = (MAX_PROD'(1) << width) | (MAX_PROD'(1) << (2 * width - 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_bw_mult_row_gen.sv
// rtl/seq_bw_mult_row_gen.sv - combinational Baugh-Wooley partial-product row generator
module bw_row_gen
  import seq_bw_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         a,
  input  logic                     b_bit,
  input  logic [$clog2(WIDTH)-1:0] row,
  input  logic                     signed_mode,
  output logic [2*WIDTH-1:0]       row_val
);

  logic [MAX_WIDTH-1:0] a_ext;
  logic [MAX_PROD-1:0]  row_full;

  // Zero-extend the multiplicand to the helper's fixed width.
  always_comb begin
    a_ext = '0;
    a_ext[WIDTH-1:0] = a;
  end

  // Build the shifted, sign-corrected row for the current multiplier bit.
  always_comb begin
    row_full = bw_row(a_ext, b_bit, int'(row), signed_mode, WIDTH);
  end

  assign row_val = row_full[2*WIDTH-1:0];

  // Bits above the product width are always zero.
  generate
    if (WIDTH < MAX_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^row_full[MAX_PROD-1:2*WIDTH];
    end
  endgenerate

endmodule

// File: rtl/seq_bw_mult.sv
// rtl/seq_bw_mult.sv - iterative Baugh-Wooley multiplier, one row per clock; SEQ_BW_MULT_EARLY_ZERO_EN enables zero-operand bypass
module seq_bw_mult
  import seq_bw_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int             RW       = $clog2(WIDTH);
  localparam int             PW       = 2 * WIDTH;
  localparam logic [RW-1:0]  LAST_ROW = RW'(WIDTH - 1);

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               signed_q;
  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      p_q;
  logic [RW-1:0]      row_q;
  logic [PW-1:0]      row_val;
  logic [PW-1:0]      acc_sum;
  logic [PW-1:0]      preload;
  logic [MAX_PROD-1:0] preload_full;
  logic               accept;
  logic               early_zero;
  logic               last_row;

  assign accept   = in_valid && (state == IDLE);
  assign last_row = (row_q == LAST_ROW);
  assign acc_sum  = acc_q + row_val;
  assign out_p    = p_q;

`ifdef SEQ_BW_MULT_EARLY_ZERO_EN
  assign early_zero = (in_a == '0) || (in_b == '0);
`else
  assign early_zero = 1'b0;
`endif

  // Preload depends on the mode presented with the accepted operation.
  always_comb begin
    preload_full = bw_preload(in_signed, WIDTH);
  end

  assign preload = preload_full[PW-1:0];

  generate
    if (PW < MAX_PROD) begin : g_pre_hi
      logic unused_pre_hi;
      assign unused_pre_hi = ^preload_full[MAX_PROD-1:PW];
    end
  endgenerate

  bw_row_gen #(
    .WIDTH (WIDTH)
  ) u_row_gen (
    .a           (a_q),
    .b_bit       (b_q[row_q]),
    .row         (row_q),
    .signed_mode (signed_q),
    .row_val     (row_val)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs; both handshakes decode only the state.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = early_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_row) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand capture, row accumulation and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      acc_q    <= '0;
      row_q    <= '0;
      p_q      <= '0;
    end else if (accept) begin
      a_q      <= in_a;
      b_q      <= in_b;
      signed_q <= in_signed;
      row_q    <= '0;
      if (early_zero) begin
        acc_q <= '0;
        p_q   <= '0;
      end else begin
        acc_q <= preload;
      end
    end else if (state == BUSY) begin
      acc_q <= acc_sum;
      row_q <= row_q + RW'(1);
      if (last_row) begin
        p_q <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_bw_mult.sv
// tb/tb_seq_bw_mult.sv - scoreboard bench for seq_bw_mult at WIDTH=4 and WIDTH=8
module tb_seq_bw_mult;

  logic        clk;
  logic        rst_n;

  logic        in_valid4, in_ready4, in_signed4, out_valid4, out_ready4;
  logic [3:0]  in_a4, in_b4;
  logic [7:0]  out_p4;

  logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
  logic [7:0]  in_a8, in_b8;
  logic [15:0] out_p8;

  int tests;
  int fails;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  seq_bw_mult #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_a      (in_a4),
    .in_b      (in_b4),
    .in_signed (in_signed4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_p     (out_p4)
  );

  seq_bw_mult #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .in_b      (in_b8),
    .in_signed (in_signed8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_p     (out_p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Scoreboard monitors: compare whenever a product handshake is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL w4_unexpected_product: got %0h expected none", out_p4);
      end else begin
        chk("w4_product", out_p4, q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL w8_unexpected_product: got %0h expected none", out_p8);
      end else begin
        chk("w8_product", out_p8, q8.pop_front());
      end
    end
  end

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     input logic [7:0] expv, input int hold);
    int n;
    n = 0;
    while (!in_ready4 && n < 50) begin @(posedge clk); #1; n++; end
    chk("w4_ready_idle", in_ready4, 1);
    in_a4 = a; in_b4 = b; in_signed4 = s; in_valid4 = 1'b1;
    q4.push_back(expv);
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_a4 = 4'($urandom); in_b4 = 4'($urandom); in_signed4 = ~s;
    n = 0;
    while (!out_valid4 && n < 100) begin
      chk("w4_ready_busy", in_ready4, 0);
      @(posedge clk); #1; n++;
    end
    chk("w4_latency", n, 4);
    for (int k = 0; k < hold; k++) begin
      in_valid4 = k[0];
      @(posedge clk); #1;
      chk("w4_hold_valid", out_valid4, 1);
      chk("w4_hold_p", out_p4, expv);
      chk("w4_hold_ready", in_ready4, 0);
    end
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("w4_post_hs_valid", out_valid4, 0);
    chk("w4_post_hs_ready", in_ready4, 1);
    chk("w4_post_hs_p", out_p4, expv);
    in_valid4 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] expv, input int hold);
    int n;
    int elat;
    elat = 8;
`ifdef SEQ_BW_MULT_EARLY_ZERO_EN
    if (a == 8'h00 || b == 8'h00) elat = 0;
`endif
    n = 0;
    while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
    chk("w8_ready_idle", in_ready8, 1);
    in_a8 = a; in_b8 = b; in_signed8 = s; in_valid8 = 1'b1;
    q8.push_back(expv);
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_a8 = 8'($urandom); in_b8 = 8'($urandom); in_signed8 = ~s;
    n = 0;
    while (!out_valid8 && n < 100) begin
      chk("w8_ready_busy", in_ready8, 0);
      @(posedge clk); #1; n++;
    end
    chk("w8_latency", n, elat);
    for (int k = 0; k < hold; k++) begin
      in_valid8 = k[0];
      @(posedge clk); #1;
      chk("w8_hold_valid", out_valid8, 1);
      chk("w8_hold_p", out_p8, expv);
      chk("w8_hold_ready", in_ready8, 0);
    end
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("w8_post_hs_valid", out_valid8, 0);
    chk("w8_post_hs_ready", in_ready8, 1);
    chk("w8_post_hs_p", out_p8, expv);
    in_valid8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_signed4 = 0; out_ready4 = 0;
    in_valid8 = 0; in_a8 = 0; in_b8 = 0; in_signed8 = 0; out_ready8 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w4_in_ready", in_ready4, 1);
    chk("rst_w4_out_valid", out_valid4, 0);
    chk("rst_w4_out_p", out_p4, 0);
    chk("rst_w8_in_ready", in_ready8, 1);
    chk("rst_w8_out_valid", out_valid8, 0);
    chk("rst_w8_out_p", out_p8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op4(4'h8, 4'h8, 1'b1, 8'h40, 0);
    op4(4'hF, 4'h7, 1'b1, 8'hF9, 0);
    op4(4'hF, 4'h7, 1'b0, 8'h69, 0);
    op4(4'h8, 4'h7, 1'b1, 8'hC8, 2);
    op4(4'h7, 4'h7, 1'b0, 8'h31, 0);

    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, 0);
    op8(8'h12, 8'h34, 1'b0, 16'h03A8, 5);
    op8(8'h00, 8'h9C, 1'b1, 16'h0000, 0);
    op8(8'h80, 8'h80, 1'b1, 16'h4000, 0);
    op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, 0);

    // Abort an operation at row 2; its result must never appear.
    in_a8 = 8'h5A; in_b8 = 8'hC3; in_signed8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midop_busy", in_ready8, 0);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_out_valid", out_valid8, 0);
    chk("midop_rst_out_p", out_p8, 0);
    chk("midop_rst_in_ready", in_ready8, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    op8(8'h03, 8'h05, 1'b1, 16'h000F, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("w4_queue_drained", q4.size(), 0);
    chk("w8_queue_drained", q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
